writeback_port: RTL
===================

# writeback_port

Write-side producer for the decode stage's GPR file, HI/LO registers and COP0 file. It merges in-order retirements from the memory stage with out-of-band results from the multi-cycle mul/div unit. It emits at most one GPR write, one HI/LO write and one COP0 write per cycle, all registered. Mul/div results that lose arbitration are buffered in a small in-order FIFO.

## Interface
Parameters:
- MD_DEPTH, 4: mul/div result FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- wb_valid  in  1  memory stage presents a retiring instruction
- wb_ready  out  1  retirement accepted this cycle (combinational)
- wb_write_reg  in  1  retirement writes a GPR
- wb_dest_reg  in  5  GPR index
- wb_reg_data  in  32  GPR data
- wb_write_hi  in  1  retirement writes HI (MTHI)
- wb_write_lo  in  1  retirement writes LO (MTLO)
- wb_hi_data  in  32  HI data
- wb_lo_data  in  32  LO data
- wb_write_cop0  in  1  retirement writes COP0 (MTC0)
- wb_cop0_rd  in  5  COP0 register index
- wb_cop0_sel  in  3  COP0 select
- wb_cop0_data  in  32  COP0 data
- md_valid  in  1  mul/div result available
- md_ready  out  1  result accepted; equals (count < MD_DEPTH)
- md_to_gpr  in  1  1: result targets GPR (MUL), data = md_lo; 0: result targets HI and LO
- md_dest_reg  in  5  GPR index when md_to_gpr
- md_hi  in  32  high result
- md_lo  in  32  low result
- write_reg  out  1  GPR write strobe to decode
- dest_reg  out  5  GPR index
- dest_reg_data  out  32  GPR data
- write_hi  out  1  HI write strobe
- dest_hi_data  out  32  HI data
- write_lo  out  1  LO write strobe
- dest_lo_data  out  32  LO data
- write_cop0  out  1  COP0 write strobe
- dest_cop0_rd  out  5  COP0 index
- dest_cop0_sel  out  3  COP0 select
- dest_cop0_data  out  32  COP0 data
- md_pending  out  $clog2(MD_DEPTH)+1  FIFO occupancy; decode uses it for hazard interlock

## Operation
- Retire accept: wb_fire = wb_valid & wb_ready.
- wb_ready = !((wb_write_hi | wb_write_lo) & (md_pending != 0 | md_valid)).
  - Non-HI/LO retirements are always accepted.
  - HI/LO retirements wait until every earlier mul/div result has drained, which preserves program order.
- MD accept: md_fire = md_valid & md_ready. On md_fire the entry {to_gpr, dest_reg, hi, lo} is pushed at the tail.
- Head pop:
  - HI/LO-type head: pops whenever the FIFO is non-empty.
  - GPR-type head: pops only when !(wb_fire & wb_write_reg). Retirement always wins the GPR port.
- Output register load, every cycle:
  - write_reg / dest_reg / dest_reg_data come from wb if wb_fire & wb_write_reg; else from a popped GPR-type head; else write_reg is 0.
  - write_hi / write_lo come from a popped HI/LO-type head (both 1, data = hi/lo); else from wb_fire & wb_write_hi/lo; else 0.
  - write_cop0 / dest_cop0_* come from wb_fire & wb_write_cop0; else write_cop0 is 0.
  - Data/index outputs hold their previous values when the corresponding strobe is 0.
- Push and pop in the same cycle leave the count unchanged. A push when count == MD_DEPTH cannot occur because md_ready is 0.
- Decode/hazard logic must not issue a GPR-writing retirement to a register that has a pending md GPR entry. This block does not check for that case.

## Timing
- Reset (async, low): all strobes 0, all data/index outputs 0, FIFO empty, md_pending = 0. md_ready is 1 and wb_ready is 1 while in reset.
- wb_fire in cycle N: strobes visible in cycle N+1. Latency is 1.
- md_fire in cycle N: entry is resident from N+1. If it pops in N+1, its strobes are visible in N+2. Minimum latency is 2.
- md_pending reflects the registered count and updates one cycle after push/pop.
- Reset asserted mid-drain: FIFO contents are discarded immediately, outputs go to 0, and no stale write is emitted after release.

## Test plan
- Reset: hold reset low, then release. All outputs are 0, md_pending = 0, md_ready = 1, wb_ready = 1.
- Plain retire: wb_write_reg, dest 5, data 0x00001234 in cycle N. Cycle N+1: write_reg = 1, dest_reg = 5, dest_reg_data = 0x00001234. Cycle N+2: write_reg = 0, data held.
- MULT result: md_to_gpr = 0, hi = 0xAAAA0000, lo = 0x00005555, FIRE in cycle N. Cycle N+2: write_hi = write_lo = 1 with those values. md_pending is 1 in N+1 only.
- GPR contention: MUL to r7 (lo = 0x77) accepted while wb writes a GPR for 3 consecutive cycles. The r7 write appears in the cycle after the last wb write's output, and md_pending stays 1 meanwhile.
- Full FIFO: 5 MUL results are offered back-to-back under continuous wb GPR writes. After 4 accepts, md_ready = 0 and md_pending = 4. When wb stops, entries drain one per cycle in push order, with no loss or duplication.
- Ordering: MTHI (hi = 0x11) arrives while one MULT entry is pending. wb_ready = 0 until the entry pops. Output order is the MULT HI/LO write, then write_hi = 1 with 0x11 in the next cycle.

Source files
------------

// File: rtl/writeback_port_if.sv
// writeback_port_if: bundles every handshake/bus signal of writeback_port.
//   master : producer side (memory stage + mul/div unit driving requests,
//            decode observing the registered write strobes)
//   slave  : the writeback_port itself
// Signals:
//   wb_*        retirement request from the memory stage, wb_ready back
//   md_*        mul/div result request, md_ready back
//   write_*/dest_*  registered GPR / HI / LO / COP0 write ports to decode
//   md_pending  mul/div FIFO occupancy for decode's hazard interlock
interface writeback_port_if #(
  parameter int MD_DEPTH = 4
);
  localparam int CNT_W = $clog2(MD_DEPTH) + 1;

  // Memory-stage retirement
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_write_reg;
  logic [4:0]  wb_dest_reg;
  logic [31:0] wb_reg_data;
  logic        wb_write_hi;
  logic        wb_write_lo;
  logic [31:0] wb_hi_data;
  logic [31:0] wb_lo_data;
  logic        wb_write_cop0;
  logic [4:0]  wb_cop0_rd;
  logic [2:0]  wb_cop0_sel;
  logic [31:0] wb_cop0_data;

  // Mul/div result
  logic        md_valid;
  logic        md_ready;
  logic        md_to_gpr;
  logic [4:0]  md_dest_reg;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  // Write ports towards decode
  logic             write_reg;
  logic [4:0]       dest_reg;
  logic [31:0]      dest_reg_data;
  logic             write_hi;
  logic [31:0]      dest_hi_data;
  logic             write_lo;
  logic [31:0]      dest_lo_data;
  logic             write_cop0;
  logic [4:0]       dest_cop0_rd;
  logic [2:0]       dest_cop0_sel;
  logic [31:0]      dest_cop0_data;
  logic [CNT_W-1:0] md_pending;

  modport master (
    output wb_valid, wb_write_reg, wb_dest_reg, wb_reg_data,
           wb_write_hi, wb_write_lo, wb_hi_data, wb_lo_data,
           wb_write_cop0, wb_cop0_rd, wb_cop0_sel, wb_cop0_data,
           md_valid, md_to_gpr, md_dest_reg, md_hi, md_lo,
    input  wb_ready, md_ready,
           write_reg, dest_reg, dest_reg_data,
           write_hi, dest_hi_data, write_lo, dest_lo_data,
           write_cop0, dest_cop0_rd, dest_cop0_sel, dest_cop0_data,
           md_pending
  );

  modport slave (
    input  wb_valid, wb_write_reg, wb_dest_reg, wb_reg_data,
           wb_write_hi, wb_write_lo, wb_hi_data, wb_lo_data,
           wb_write_cop0, wb_cop0_rd, wb_cop0_sel, wb_cop0_data,
           md_valid, md_to_gpr, md_dest_reg, md_hi, md_lo,
    output wb_ready, md_ready,
           write_reg, dest_reg, dest_reg_data,
           write_hi, dest_hi_data, write_lo, dest_lo_data,
           write_cop0, dest_cop0_rd, dest_cop0_sel, dest_cop0_data,
           md_pending
  );
endinterface

// File: rtl/writeback_port.sv
// writeback_port: write-side producer for decode's GPR file, HI/LO and COP0.
// Merges in-order retirements from the memory stage with out-of-band
// mul/div results. At most one GPR, one HI/LO and one COP0 write per cycle,
// all registered. Mul/div results that cannot issue immediately wait in an
// in-order FIFO of MD_DEPTH entries (power of two, >= 2).
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     writeback_port_if.slave (request/ready handshakes, write ports,
//           md_pending)
module writeback_port #(
  parameter int MD_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  writeback_port_if.slave   bus
);
  localparam int PTR_W = $clog2(MD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MD_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1);

  // FIFO storage and bookkeeping
  logic             fifo_to_gpr_q [MD_DEPTH];
  logic [4:0]       fifo_dest_q   [MD_DEPTH];
  logic [31:0]      fifo_hi_q     [MD_DEPTH];
  logic [31:0]      fifo_lo_q     [MD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Output registers
  logic        write_reg_q, write_reg_d;
  logic [4:0]  dest_reg_q, dest_reg_d;
  logic [31:0] dest_reg_data_q, dest_reg_data_d;
  logic        write_hi_q, write_hi_d;
  logic [31:0] dest_hi_data_q, dest_hi_data_d;
  logic        write_lo_q, write_lo_d;
  logic [31:0] dest_lo_data_q, dest_lo_data_d;
  logic        write_cop0_q, write_cop0_d;
  logic [4:0]  dest_cop0_rd_q, dest_cop0_rd_d;
  logic [2:0]  dest_cop0_sel_q, dest_cop0_sel_d;
  logic [31:0] dest_cop0_data_q, dest_cop0_data_d;

  // Handshake / arbitration signals
  logic fifo_empty_s;
  logic wb_hilo_s;
  logic wb_ready_s;
  logic md_ready_s;
  logic wb_fire_s;
  logic md_fire_s;
  logic wb_gpr_s;
  logic head_gpr_s;
  logic pop_s;
  logic pop_gpr_s;
  logic pop_hilo_s;

  assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
  assign wb_hilo_s    = bus.wb_write_hi | bus.wb_write_lo;

  // An HI/LO retirement must not overtake an older mul/div result, whether
  // that result is already queued or is being offered this very cycle.
  assign wb_ready_s = ~(wb_hilo_s & (~fifo_empty_s | bus.md_valid));
  assign md_ready_s = (count_q < DEPTH_C);

  assign wb_fire_s = bus.wb_valid & wb_ready_s;
  assign md_fire_s = bus.md_valid & md_ready_s;
  assign wb_gpr_s  = wb_fire_s & bus.wb_write_reg;

  // A GPR-type head yields the GPR port to retirement; an HI/LO-type head
  // never conflicts because wb_ready blocks HI/LO retirements while queued.
  assign head_gpr_s = fifo_to_gpr_q[rd_ptr_q];
  assign pop_s      = ~fifo_empty_s & (~head_gpr_s | ~wb_gpr_s);
  assign pop_gpr_s  = pop_s & head_gpr_s;
  assign pop_hilo_s = pop_s & ~head_gpr_s;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (md_fire_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE_C;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({md_fire_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE_C;
      2'b01:   count_d = count_q - CNT_ONE_C;
      default: count_d = count_q;
    endcase
  end

  // FIFO state and storage registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < MD_DEPTH; i++) begin
        fifo_to_gpr_q[i] <= 1'b0;
        fifo_dest_q[i]   <= 5'd0;
        fifo_hi_q[i]     <= 32'h0000_0000;
        fifo_lo_q[i]     <= 32'h0000_0000;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (md_fire_s) begin
        fifo_to_gpr_q[wr_ptr_q] <= bus.md_to_gpr;
        fifo_dest_q[wr_ptr_q]   <= bus.md_dest_reg;
        fifo_hi_q[wr_ptr_q]     <= bus.md_hi;
        fifo_lo_q[wr_ptr_q]     <= bus.md_lo;
      end
    end
  end

  // GPR port select: retirement first, then a GPR-type FIFO head
  always_comb begin
    write_reg_d     = 1'b0;
    dest_reg_d      = dest_reg_q;
    dest_reg_data_d = dest_reg_data_q;
    if (wb_gpr_s) begin
      write_reg_d     = 1'b1;
      dest_reg_d      = bus.wb_dest_reg;
      dest_reg_data_d = bus.wb_reg_data;
    end else if (pop_gpr_s) begin
      write_reg_d     = 1'b1;
      dest_reg_d      = fifo_dest_q[rd_ptr_q];
      dest_reg_data_d = fifo_lo_q[rd_ptr_q];
    end else begin
      write_reg_d = 1'b0;
    end
  end

  // HI/LO port select: an HI/LO-type FIFO head writes both halves
  always_comb begin
    write_hi_d     = 1'b0;
    dest_hi_data_d = dest_hi_data_q;
    write_lo_d     = 1'b0;
    dest_lo_data_d = dest_lo_data_q;
    if (pop_hilo_s) begin
      write_hi_d     = 1'b1;
      dest_hi_data_d = fifo_hi_q[rd_ptr_q];
      write_lo_d     = 1'b1;
      dest_lo_data_d = fifo_lo_q[rd_ptr_q];
    end else begin
      if (wb_fire_s & bus.wb_write_hi) begin
        write_hi_d     = 1'b1;
        dest_hi_data_d = bus.wb_hi_data;
      end else begin
        write_hi_d = 1'b0;
      end
      if (wb_fire_s & bus.wb_write_lo) begin
        write_lo_d     = 1'b1;
        dest_lo_data_d = bus.wb_lo_data;
      end else begin
        write_lo_d = 1'b0;
      end
    end
  end

  // COP0 port select: only retirements write COP0
  always_comb begin
    write_cop0_d     = 1'b0;
    dest_cop0_rd_d   = dest_cop0_rd_q;
    dest_cop0_sel_d  = dest_cop0_sel_q;
    dest_cop0_data_d = dest_cop0_data_q;
    if (wb_fire_s & bus.wb_write_cop0) begin
      write_cop0_d     = 1'b1;
      dest_cop0_rd_d   = bus.wb_cop0_rd;
      dest_cop0_sel_d  = bus.wb_cop0_sel;
      dest_cop0_data_d = bus.wb_cop0_data;
    end else begin
      write_cop0_d = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_reg_q      <= 1'b0;
      dest_reg_q       <= 5'd0;
      dest_reg_data_q  <= 32'h0000_0000;
      write_hi_q       <= 1'b0;
      dest_hi_data_q   <= 32'h0000_0000;
      write_lo_q       <= 1'b0;
      dest_lo_data_q   <= 32'h0000_0000;
      write_cop0_q     <= 1'b0;
      dest_cop0_rd_q   <= 5'd0;
      dest_cop0_sel_q  <= 3'd0;
      dest_cop0_data_q <= 32'h0000_0000;
    end else begin
      write_reg_q      <= write_reg_d;
      dest_reg_q       <= dest_reg_d;
      dest_reg_data_q  <= dest_reg_data_d;
      write_hi_q       <= write_hi_d;
      dest_hi_data_q   <= dest_hi_data_d;
      write_lo_q       <= write_lo_d;
      dest_lo_data_q   <= dest_lo_data_d;
      write_cop0_q     <= write_cop0_d;
      dest_cop0_rd_q   <= dest_cop0_rd_d;
      dest_cop0_sel_q  <= dest_cop0_sel_d;
      dest_cop0_data_q <= dest_cop0_data_d;
    end
  end

  assign bus.wb_ready       = wb_ready_s;
  assign bus.md_ready       = md_ready_s;
  assign bus.md_pending     = count_q;
  assign bus.write_reg      = write_reg_q;
  assign bus.dest_reg       = dest_reg_q;
  assign bus.dest_reg_data  = dest_reg_data_q;
  assign bus.write_hi       = write_hi_q;
  assign bus.dest_hi_data   = dest_hi_data_q;
  assign bus.write_lo       = write_lo_q;
  assign bus.dest_lo_data   = dest_lo_data_q;
  assign bus.write_cop0     = write_cop0_q;
  assign bus.dest_cop0_rd   = dest_cop0_rd_q;
  assign bus.dest_cop0_sel  = dest_cop0_sel_q;
  assign bus.dest_cop0_data = dest_cop0_data_q;
endmodule
